keypad_display_arbiter: RTL

Shares the single 12-key keypad and the 6-digit BCD display among `N_CLIENTS` function blocks (clock, stopwatch, countdown timer). It enables exactly one active client, forwards each new key press to the correct client with an acknowledge handshake, and selects which client's 24-bit BCD word is displayed. Clients raising an alert take over the display and the next key press. It sits between the keypad scanner / FND driver and the function blocks.

---
 rtl/keypad_display_arbiter_pkg.sv | 26 ++
 rtl/keypad_display_arbiter_sync2.sv | 23 ++
 rtl/keypad_display_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/keypad_display_arbiter_pkg.sv
// Shared key codes, widths and key-FSM encoding for the keypad/display arbiter.
package keypad_display_arbiter_pkg;
  localparam int KEY_W  = 12;
  localparam int DATA_W = 24;

  localparam logic [KEY_W-1:0] KEY_NONE = 12'h000;
  localparam logic [KEY_W-1:0] KEY_1    = 12'h001;
  localparam logic [KEY_W-1:0] KEY_2    = 12'h002;
  localparam logic [KEY_W-1:0] KEY_3    = 12'h004;
  localparam logic [KEY_W-1:0] KEY_4    = 12'h008;
  localparam logic [KEY_W-1:0] KEY_5    = 12'h010;
  localparam logic [KEY_W-1:0] KEY_6    = 12'h020;
  localparam logic [KEY_W-1:0] KEY_7    = 12'h040;
  localparam logic [KEY_W-1:0] KEY_8    = 12'h080;
  localparam logic [KEY_W-1:0] KEY_9    = 12'h100;
  localparam logic [KEY_W-1:0] KEY_STAR = 12'h200;
  localparam logic [KEY_W-1:0] KEY_0    = 12'h400;
  localparam logic [KEY_W-1:0] KEY_HASH = 12'h800;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_RELEASE} key_st_e;

  // Chords (several keys at once) are not valid presses.
  function automatic logic is_onehot(input logic [KEY_W-1:0] k);
    return (k != KEY_NONE) && ((k & (k - 12'd1)) == KEY_NONE);
  endfunction
endpackage

// File: rtl/keypad_display_arbiter_sync2.sv
// Two-flop synchroniser for asynchronous button/keypad levels.
module keypad_display_arbiter_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/keypad_display_arbiter.sv
// Routes keypad presses to one of N function blocks and picks the displayed word;
// alerting clients pre-empt both the display and the next key press.
module keypad_display_arbiter
  import keypad_display_arbiter_pkg::*;
#(
  parameter int N_CLIENTS   = 3,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [KEY_W-1:0]            key_in,
  input  logic                        mode_btn,
  input  logic [DATA_W*N_CLIENTS-1:0] cli_data,
  input  logic [N_CLIENTS-1:0]        cli_ack,
  input  logic [N_CLIENTS-1:0]        cli_alert,
  output logic [N_CLIENTS-1:0]        cli_en,
  output logic [KEY_W*N_CLIENTS-1:0]  cli_key,
  output logic [DATA_W-1:0]           disp_data,
  output logic [1:0]                  disp_src,
  output logic                        light_o,
  output logic                        key_drop
);
  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [1:0] LAST_IDX = 2'(N_CLIENTS - 1);

  logic [KEY_W-1:0]  key_s, key_q, key_d;
  logic              mode_s, mode_prev_q, mode_rise, leave;
  key_st_e           state_q, state_d;
  logic [1:0]        tgt_q, tgt_d, active_q, active_d, sel;
  logic [7:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d, drop_q, drop_d;
  logic [DATA_W-1:0] disp_q;
  logic [1:0]        src_q;
  logic              light_q;

  keypad_display_arbiter_sync2 #(.W(KEY_W)) u_sync_key (
    .clk(clk), .rst_n(rst_n), .d_i(key_in), .q_o(key_s));
  keypad_display_arbiter_sync2 #(.W(1)) u_sync_mode (
    .clk(clk), .rst_n(rst_n), .d_i(mode_btn), .q_o(mode_s));

  // Lowest-index alerting client wins; otherwise the user-selected client.
  always_comb begin
    sel = active_q;
    for (int i = N_CLIENTS - 1; i >= 0; i--)
      if (cli_alert[i]) sel = 2'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    unique case (state_q)
      ST_IDLE:
        if (is_onehot(key_s)) begin
          key_d   = key_s;
          tgt_d   = sel;
          cnt_d   = '0;
          state_d = ST_PRESENT;
        end
      ST_PRESENT:
        if (cli_ack[tgt_q]) begin
          key_d   = KEY_NONE;
          state_d = ST_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          key_d   = KEY_NONE;
          drop_d  = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      ST_RELEASE:
        if (key_s == KEY_NONE) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cli_key = '0;
    if (state_q == ST_PRESENT) cli_key[tgt_q*KEY_W +: KEY_W] = key_q;
  end

  // Mode changes never retarget a key in flight: one is parked until PRESENT ends.
  assign mode_rise = mode_s & ~mode_prev_q;
  assign leave     = (state_q == ST_PRESENT) && (state_d != ST_PRESENT);

  always_comb begin
    active_d = active_q;
    pend_d   = pend_q;
    if (state_q != ST_PRESENT) begin
      if (mode_rise) active_d = (active_q == LAST_IDX) ? 2'd0 : active_q + 2'd1;
    end else if (leave) begin
      if (pend_q || mode_rise) active_d = (active_q == LAST_IDX) ? 2'd0 : active_q + 2'd1;
      pend_d = 1'b0;
    end else if (mode_rise) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= KEY_NONE;
      tgt_q       <= '0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      active_q    <= '0;
      pend_q      <= 1'b0;
      mode_prev_q <= 1'b0;
      disp_q      <= '0;
      src_q       <= '0;
      light_q     <= 1'b0;
    end else begin
      key_q       <= key_d;
      tgt_q       <= tgt_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      mode_prev_q <= mode_s;
      disp_q      <= cli_data[sel*DATA_W +: DATA_W];
      src_q       <= sel;
      light_q     <= |cli_alert;
    end
  end

  always_comb begin
    cli_en           = '0;
    cli_en[active_q] = 1'b1;
  end

  assign disp_data = disp_q;
  assign disp_src  = src_q;
  assign light_o   = light_q;
  assign key_drop  = drop_q;
endmodule
